// File: rtl/vga_pkg.sv
// Shared VGA timing types and the default 640x480@60 Hz segment lengths.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} vga_phase_t;
    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus the VISIBLE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VIS_LEN   = DEF_H_VISIBLE,
    parameter int FRONT_LEN = DEF_H_FRONT,
    parameter int SYNC_LEN  = DEF_H_SYNC,
    parameter int BACK_LEN  = DEF_H_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output coord_t     count_o,
    output vga_phase_t phase_o,
    output logic       wrap_o
);

    localparam coord_t VIS_END   = coord_t'(VIS_LEN - 1);
    localparam coord_t FRONT_END = coord_t'(VIS_LEN + FRONT_LEN - 1);
    localparam coord_t SYNC_END  = coord_t'(VIS_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam coord_t LAST      = coord_t'(VIS_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

    coord_t     count_q, count_d;
    vga_phase_t phase_q, phase_d;

    assign wrap_o  = (count_q == LAST);
    assign count_o = count_q;
    assign phase_o = phase_q;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (adv) begin
            count_d = wrap_o ? '0 : count_q + coord_t'(1);
            // The phase leaves on its last index, so it stays aligned with count.
            case (phase_q)
                VISIBLE: if (count_q == VIS_END)   phase_d = FRONT;
                FRONT:   if (count_q == FRONT_END) phase_d = SYNC;
                SYNC:    if (count_q == SYNC_END)  phase_d = BACK;
                BACK:    if (count_q == LAST)      phase_d = VISIBLE;
                default: phase_d = VISIBLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= VISIBLE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, H/V axis counters and one output register stage
// that keeps coordinates, syncs, blank and strobes on the same Clk edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic   Clk,
    input  logic   Reset_n,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   VGA_HS,
    output logic   VGA_VS,
    output logic   VGA_BLANK_N,
    output logic   VGA_SYNC_N,
    output logic   VGA_CLK,
    output logic   pix_en,
    output logic   frame_start,
    output logic   vblank_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam coord_t V_VIS_LAST = coord_t'(V_VISIBLE - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_adv, line_adv, h_wrap, v_wrap;
    coord_t           h_count, v_count;
    vga_phase_t       h_phase, v_phase;

    logic   frame_pend_q, vblank_pend_q;
    coord_t draw_x_q, draw_y_q;
    logic   hs_q, vs_q, blank_n_q, pix_en_q, frame_start_q, vblank_start_q;

    assign pix_adv   = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = pix_adv ? '0 : div_cnt_q + DIV_W'(1);
    assign line_adv  = pix_adv && h_wrap;

    vga_axis_counter #(
        .VIS_LEN(H_VISIBLE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
    ) u_h_axis (
        .clk(Clk), .rst_n(Reset_n), .adv(pix_adv),
        .count_o(h_count), .phase_o(h_phase), .wrap_o(h_wrap)
    );

    vga_axis_counter #(
        .VIS_LEN(V_VISIBLE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
    ) u_v_axis (
        .clk(Clk), .rst_n(Reset_n), .adv(line_adv),
        .count_o(v_count), .phase_o(v_phase), .wrap_o(v_wrap)
    );

    // Everything below is sampled from the counter state one edge later, so the
    // event strobes need one extra pending stage to land on the pixel they mark.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q      <= '0;
            frame_pend_q   <= 1'b0;
            vblank_pend_q  <= 1'b0;
            draw_x_q       <= '0;
            draw_y_q       <= '0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            blank_n_q      <= 1'b0;
            pix_en_q       <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            frame_pend_q   <= line_adv && v_wrap;
            vblank_pend_q  <= line_adv && (v_count == V_VIS_LAST);
            draw_x_q       <= h_count;
            draw_y_q       <= v_count;
            hs_q           <= (h_phase != SYNC);
            vs_q           <= (v_phase != SYNC);
            blank_n_q      <= (h_phase == VISIBLE) && (v_phase == VISIBLE);
            pix_en_q       <= pix_adv;
            frame_start_q  <= frame_pend_q;
            vblank_start_q <= vblank_pend_q;
        end
    end

    generate
        if (CLK_DIV == 1) begin : gen_clk_direct
            // No divided phase exists, so the DAC samples on the falling system edge.
            assign VGA_CLK = ~Clk & Reset_n;
        end else begin : gen_clk_reg
            localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
            logic vga_clk_q;
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) vga_clk_q <= 1'b0;
                else          vga_clk_q <= (div_cnt_q >= DIV_HALF);
            end
            assign VGA_CLK = vga_clk_q;
        end
    endgenerate

    assign DrawX        = draw_x_q;
    assign DrawY        = draw_y_q;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign VGA_SYNC_N   = 1'b0;
    assign pix_en       = pix_en_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing at CLK_DIV 2 and 1, plus a shrunken raster for frame-level checks.
module tb_vga_timing_gen;

    logic Clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_hs, a_vs, a_blank, a_syncn, a_vclk, a_pix, a_fs, a_vbs;
    logic b_hs, b_vs, b_blank, b_syncn, b_vclk, b_pix, b_fs, b_vbs;
    logic c_hs, c_vs, c_blank, c_syncn, c_vclk, c_pix, c_fs, c_vbs;

    vga_timing_gen #(.CLK_DIV(2)) dut_a (
        .Clk(Clk), .Reset_n(rst_n), .DrawX(a_x), .DrawY(a_y), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_syncn), .VGA_CLK(a_vclk), .pix_en(a_pix),
        .frame_start(a_fs), .vblank_start(a_vbs)
    );

    vga_timing_gen #(.CLK_DIV(1)) dut_b (
        .Clk(Clk), .Reset_n(rst_n), .DrawX(b_x), .DrawY(b_y), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_syncn), .VGA_CLK(b_vclk), .pix_en(b_pix),
        .frame_start(b_fs), .vblank_start(b_vbs)
    );

    // H: 8/2/3/2 (total 15), V: 6/2/2/3 (total 13) -> 195 pixels, 390 Clk per frame.
    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_c (
        .Clk(Clk), .Reset_n(rst_n), .DrawX(c_x), .DrawY(c_y), .VGA_HS(c_hs), .VGA_VS(c_vs),
        .VGA_BLANK_N(c_blank), .VGA_SYNC_N(c_syncn), .VGA_CLK(c_vclk), .pix_en(c_pix),
        .frame_start(c_fs), .vblank_start(c_vbs)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [21:0] got, exp;
        logic [9:0]  exp_x;
        rst_n = 1'b0;
        repeat (5) step();
        exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        got = {a_x, a_y, a_hs, a_vs, a_blank, a_syncn, a_vclk, a_pix, a_fs, a_vbs};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_state_a: got %h want %h", got, exp);
        end
        got = {b_x, b_y, b_hs, b_vs, b_blank, b_syncn, b_vclk, b_pix, b_fs, b_vbs};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_state_div1: got %h want %h", got, exp);
        end
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_x = 10'((k - 1) / 2);
            total++;
            if (a_x !== exp_x || a_y !== 10'd0) begin
                bad++;
                $display("FAIL reset_release_x: cycle %0d got (%0d,%0d) want (%0d,0)", k, a_x, a_y, exp_x);
            end
            if (k == 1) begin
                total++;
                if ({a_blank, a_pix, a_vclk} !== 3'b100) begin
                    bad++;
                    $display("FAIL first_cycle: blank/pix/vclk got %b want 100", {a_blank, a_pix, a_vclk});
                end
            end
            if (k == 2 || k == 3) begin
                total++;
                if (a_pix !== (k == 2) || a_vclk !== (k == 2)) begin
                    bad++;
                    $display("FAIL pix_vclk_phase: cycle %0d got pix=%b vclk=%b want %b", k, a_pix, a_vclk, k == 2);
                end
            end
            $display("reset k=%0d DrawX=%0d pix_en=%b VGA_CLK=%b", k, a_x, a_pix, a_vclk);
        end
    endtask

    task automatic test_line();
        int hs_cnt, first_hs, last_hs, first_blank, syncn_bad, wrap_prev, wrap_x;
        logic [9:0] prev_x;
        logic seen_wrap;
        do_reset();
        hs_cnt = 0; first_hs = -1; last_hs = -1; first_blank = -1; syncn_bad = 0;
        seen_wrap = 1'b0; wrap_prev = -1; wrap_x = -1; prev_x = 10'd0;
        for (int k = 1; k <= 1700; k++) begin
            step();
            if (a_y == 10'd0 && a_hs == 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(a_x);
                last_hs = int'(a_x);
            end
            if (a_y == 10'd0 && a_blank == 1'b0 && first_blank < 0) first_blank = int'(a_x);
            if (a_syncn !== 1'b0) syncn_bad++;
            if (a_y == 10'd1 && !seen_wrap) begin
                seen_wrap = 1'b1;
                wrap_prev = int'(prev_x);
                wrap_x = int'(a_x);
            end
            prev_x = a_x;
        end
        $display("line hs_cnt=%0d hs=[%0d..%0d] blank_drop=%0d wrap=%0d->%0d", hs_cnt, first_hs, last_hs, first_blank, wrap_prev, wrap_x);
        total++;
        if (hs_cnt != 192) begin bad++; $display("FAIL hs_width: got %0d clk want 192", hs_cnt); end
        total++;
        if (first_hs != 656 || last_hs != 751) begin
            bad++;
            $display("FAIL hs_span: got %0d..%0d want 656..751", first_hs, last_hs);
        end
        total++;
        if (first_blank != 640) begin bad++; $display("FAIL blank_drop: got x=%0d want 640", first_blank); end
        total++;
        if (wrap_prev != 799 || wrap_x != 0) begin
            bad++;
            $display("FAIL line_wrap: got %0d->%0d want 799->0", wrap_prev, wrap_x);
        end
        total++;
        if (syncn_bad != 0) begin bad++; $display("FAIL sync_n: got %0d nonzero samples want 0", syncn_bad); end
    endtask

    task automatic test_frames();
        int fs_cnt, fs_first, fs_second, fs_pos_bad, vbs_cnt, vbs_pos_bad, vs_bad, blank_bad, pix_cnt;
        do_reset();
        fs_cnt = 0; fs_first = -1; fs_second = -1; fs_pos_bad = 0;
        vbs_cnt = 0; vbs_pos_bad = 0; vs_bad = 0; blank_bad = 0; pix_cnt = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            if (c_fs === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k; else if (fs_second < 0) fs_second = k;
                if (c_x != 10'd0 || c_y != 10'd0) fs_pos_bad++;
            end
            if (c_vbs === 1'b1) begin
                vbs_cnt++;
                if (c_x != 10'd0 || c_y != 10'd6) vbs_pos_bad++;
            end
            if ((c_vs === 1'b0) != (c_y == 10'd8 || c_y == 10'd9)) vs_bad++;
            if (c_y >= 10'd6 && c_blank !== 1'b0) blank_bad++;
            if (fs_first > 0 && fs_second < 0 && c_pix === 1'b1) pix_cnt++;
        end
        $display("frames fs=%0d at %0d,%0d vbs=%0d pix_per_frame=%0d", fs_cnt, fs_first, fs_second, vbs_cnt, pix_cnt);
        total++;
        if (fs_cnt != 2 || fs_first != 391 || fs_second != 781) begin
            bad++;
            $display("FAIL frame_start_timing: got n=%0d at %0d,%0d want n=2 at 391,781", fs_cnt, fs_first, fs_second);
        end
        total++;
        if (fs_pos_bad != 0) begin bad++; $display("FAIL frame_start_pos: got %0d off-origin pulses want 0", fs_pos_bad); end
        total++;
        if (vbs_cnt != 2 || vbs_pos_bad != 0) begin
            bad++;
            $display("FAIL vblank_start: got n=%0d misplaced=%0d want n=2 misplaced=0", vbs_cnt, vbs_pos_bad);
        end
        total++;
        if (vs_bad != 0) begin bad++; $display("FAIL vs_lines: got %0d wrong samples want 0", vs_bad); end
        total++;
        if (blank_bad != 0) begin bad++; $display("FAIL vblank_blank: got %0d visible samples want 0", blank_bad); end
        total++;
        if (pix_cnt != 195) begin bad++; $display("FAIL pix_per_frame: got %0d want 195", pix_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [21:0] got, exp;
        bit found;
        int fs_cnt;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            step();
            if (c_x == 10'd5 && c_y == 10'd8) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_reset_reach: got no (5,8) within 1000 clk want reached"); end
        rst_n = 1'b0;
        #1;
        exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        got = {c_x, c_y, c_hs, c_vs, c_blank, c_syncn, c_vclk, c_pix, c_fs, c_vbs};
        $display("mid_reset async outputs=%h", got);
        total++;
        if (got !== exp) begin bad++; $display("FAIL mid_reset_async: got %h want %h", got, exp); end
        repeat (3) step();
        rst_n = 1'b1;
        cyc = 0;
        fs_cnt = 0;
        for (int k = 1; k <= 380; k++) begin
            step();
            if (c_fs === 1'b1) fs_cnt++;
            if (k == 1 || k == 3) begin
                total++;
                if (c_x !== 10'((k - 1) / 2) || c_y !== 10'd0) begin
                    bad++;
                    $display("FAIL mid_reset_restart: cycle %0d got (%0d,%0d) want (%0d,0)", k, c_x, c_y, (k - 1) / 2);
                end
            end
        end
        total++;
        if (fs_cnt != 0) begin bad++; $display("FAIL mid_reset_no_fs: got %0d pulses want 0", fs_cnt); end
    endtask

    task automatic test_div1();
        int pix_bad, x_bad, hs_cnt;
        do_reset();
        pix_bad = 0; x_bad = 0; hs_cnt = 0;
        for (int k = 1; k <= 799; k++) begin
            step();
            if (b_pix !== 1'b1) pix_bad++;
            if (b_x !== 10'(k - 1)) x_bad++;
            if (b_hs === 1'b0) hs_cnt++;
        end
        $display("div1 pix_bad=%0d x_bad=%0d hs_cnt=%0d", pix_bad, x_bad, hs_cnt);
        total++;
        if (pix_bad != 0) begin bad++; $display("FAIL div1_pix_en: got %0d low samples want 0", pix_bad); end
        total++;
        if (x_bad != 0) begin bad++; $display("FAIL div1_x_step: got %0d wrong samples want 0", x_bad); end
        total++;
        if (hs_cnt != 96) begin bad++; $display("FAIL div1_hs_width: got %0d clk want 96", hs_cnt); end
        @(negedge Clk);
        #1;
        total++;
        if (b_vclk !== 1'b1) begin bad++; $display("FAIL div1_vga_clk: got %b with Clk low want 1", b_vclk); end
    endtask

    initial begin
        Clk = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad = 0;
        cyc = 0;
        test_reset();
        test_line();
        test_frames();
        test_mid_reset();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
